// File: rtl/param_stack.sv
// param_stack: LIFO with registered top-of-stack, occupancy, status flags and sticky error flags.
module param_stack #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 32,
   parameter int AFULL_THRESH  = 28,
   parameter int AEMPTY_THRESH = 4,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PUSH,
   input  logic                  POP,
   input  logic                  FLUSH,
   input  logic                  CLR_ERR,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic [DATA_WIDTH-1:0] TOP,
   output logic [CW-1:0]         COUNT,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  full_c, rep, psh, pp, wr_en, ovf_ev, unf_ev;
   logic [AW-1:0]         wr_idx;
   logic [CW-1:0]         cnt_nx;
   logic [DATA_WIDTH-1:0] top_nx, below;
   // A push+pop on an empty stack degenerates to a plain push.
   always_comb begin
      full_c = (COUNT == CW'(DEPTH));
      rep    = PUSH && POP && (COUNT != '0);
      psh    = PUSH && !rep;
      pp     = POP && !PUSH;
      ovf_ev = !FLUSH && psh && full_c;
      unf_ev = !FLUSH && pp && (COUNT == '0);
      wr_en  = !FLUSH && (rep || (psh && !full_c));
      wr_idx = rep ? AW'(COUNT - CW'(1)) : AW'(COUNT);
      below  = (COUNT >= CW'(2)) ? mem[AW'(COUNT - CW'(2))] : '0;
      cnt_nx = FLUSH ? '0
             : (psh && !full_c) ? COUNT + CW'(1)
             : (pp && COUNT != '0) ? COUNT - CW'(1)
             : COUNT;
      top_nx = FLUSH ? '0
             : wr_en ? DATA_IN
             : (pp && COUNT != '0) ? below
             : TOP;
   end
   always_ff @(posedge CLK)
      if (!RST && wr_en) mem[wr_idx] <= DATA_IN;
   always_ff @(posedge CLK) begin
      if (RST) begin
         COUNT        <= '0;
         TOP          <= '0;
         FULL         <= 1'b0;
         EMPTY        <= 1'b1;
         ALMOST_FULL  <= (AFULL_THRESH <= 0);
         ALMOST_EMPTY <= 1'b1;
         OVERFLOW     <= 1'b0;
         UNDERFLOW    <= 1'b0;
      end else begin
         COUNT        <= cnt_nx;
         TOP          <= top_nx;
         FULL         <= (cnt_nx == CW'(DEPTH));
         EMPTY        <= (cnt_nx == '0);
         ALMOST_FULL  <= (int'(cnt_nx) >= AFULL_THRESH);
         ALMOST_EMPTY <= (int'(cnt_nx) <= AEMPTY_THRESH);
         OVERFLOW     <= (OVERFLOW && !CLR_ERR) || ovf_ev;
         UNDERFLOW    <= (UNDERFLOW && !CLR_ERR) || unf_ev;
      end
   end
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed vectors feed an expectation queue; a monitor compares every cycle's outputs.
module tb_param_stack;
   logic       CLK = 1'b0, RST = 1'b1, PUSH = 1'b0, POP = 1'b0, FLUSH = 1'b0, CLR_ERR = 1'b0;
   logic [7:0] DATA_IN = '0, TOP;
   logic [2:0] COUNT;
   logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
   int         checks = 0, failures = 0;
   typedef struct {
      string       nm;
      logic [16:0] v;
   } exp_t;
   exp_t q[$];

   param_stack #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
      .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
      .DATA_IN(DATA_IN), .TOP(TOP), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
      .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   // flags order: full empty almost_full almost_empty overflow underflow
   task automatic op(input string nm, input logic r, fl, ps, pp, ce, input logic [7:0] d,
                     input logic [7:0] et, input logic [2:0] ec, input logic [5:0] ef);
      exp_t e;
      @(negedge CLK);
      RST = r; FLUSH = fl; PUSH = ps; POP = pp; CLR_ERR = ce; DATA_IN = d;
      e.nm = nm;
      e.v  = {et, ec, ef};
      q.push_back(e);
      @(posedge CLK);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [16:0] act;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {TOP, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW};
            checks++;
            if (act !== e.v) begin
               failures++;
               $display("FAIL %s: got top=%h cnt=%0d flags=%b, want top=%h cnt=%0d flags=%b",
                        e.nm, act[16:9], act[8:6], act[5:0], e.v[16:9], e.v[8:6], e.v[5:0]);
            end
         end
      end
   end

   initial begin : stim
      op("reset",        1,0,0,0,0, 8'h00, 8'h00, 3'd0, 6'b010100);
      op("push11",       0,0,1,0,0, 8'h11, 8'h11, 3'd1, 6'b000100);
      op("push22",       0,0,1,0,0, 8'h22, 8'h22, 3'd2, 6'b000000);
      op("push33",       0,0,1,0,0, 8'h33, 8'h33, 3'd3, 6'b001000);
      op("push44",       0,0,1,0,0, 8'h44, 8'h44, 3'd4, 6'b101000);
      op("push_full",    0,0,1,0,0, 8'h55, 8'h44, 3'd4, 6'b101010);
      op("pop1",         0,0,0,1,0, 8'h00, 8'h33, 3'd3, 6'b001010);
      op("pop2",         0,0,0,1,0, 8'h00, 8'h22, 3'd2, 6'b000010);
      op("pop3",         0,0,0,1,0, 8'h00, 8'h11, 3'd1, 6'b000110);
      op("pop4",         0,0,0,1,0, 8'h00, 8'h00, 3'd0, 6'b010110);
      op("pop_empty",    0,0,0,1,0, 8'h00, 8'h00, 3'd0, 6'b010111);
      op("clr_both",     0,0,0,0,1, 8'h00, 8'h00, 3'd0, 6'b010100);
      op("push11b",      0,0,1,0,0, 8'h11, 8'h11, 3'd1, 6'b000100);
      op("push22b",      0,0,1,0,0, 8'h22, 8'h22, 3'd2, 6'b000000);
      op("replace99",    0,0,1,1,0, 8'h99, 8'h99, 3'd2, 6'b000000);
      op("pop_after_rep",0,0,0,1,0, 8'h00, 8'h11, 3'd1, 6'b000100);
      op("pop_to_empty", 0,0,0,1,0, 8'h00, 8'h00, 3'd0, 6'b010100);
      op("pushpop_empty",0,0,1,1,0, 8'h77, 8'h77, 3'd1, 6'b000100);
      op("push88",       0,0,1,0,0, 8'h88, 8'h88, 3'd2, 6'b000000);
      op("push66",       0,0,1,0,0, 8'h66, 8'h66, 3'd3, 6'b001000);
      op("flush_push",   0,1,1,0,0, 8'h12, 8'h00, 3'd0, 6'b010100);
      op("fill1",        0,0,1,0,0, 8'h01, 8'h01, 3'd1, 6'b000100);
      op("fill2",        0,0,1,0,0, 8'h02, 8'h02, 3'd2, 6'b000000);
      op("fill3",        0,0,1,0,0, 8'h03, 8'h03, 3'd3, 6'b001000);
      op("fill4",        0,0,1,0,0, 8'h04, 8'h04, 3'd4, 6'b101000);
      op("overflow2",    0,0,1,0,0, 8'h05, 8'h04, 3'd4, 6'b101010);
      op("clr_vs_ovf",   0,0,1,0,1, 8'h06, 8'h04, 3'd4, 6'b101010);
      op("clr_ovf",      0,0,0,0,1, 8'h00, 8'h04, 3'd4, 6'b101000);
      op("replace_full", 0,0,1,1,0, 8'hAA, 8'hAA, 3'd4, 6'b101000);
      op("pop_below_rep",0,0,0,1,0, 8'h00, 8'h03, 3'd3, 6'b001000);
      op("pop_to2",      0,0,0,1,0, 8'h00, 8'h02, 3'd2, 6'b000000);
      op("rst_with_push",1,0,1,0,0, 8'hFF, 8'h00, 3'd0, 6'b010100);
      op("pushA5",       0,0,1,0,0, 8'hA5, 8'hA5, 3'd1, 6'b000100);
      op("popA5",        0,0,0,1,0, 8'h00, 8'h00, 3'd0, 6'b010100);
      @(negedge CLK);
      PUSH = 0; POP = 0; FLUSH = 0; CLR_ERR = 0; RST = 0;
      repeat (3) @(posedge CLK);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
